// File: rtl/extmem_seq.sv
// rtl/extmem_seq.sv - external memory cycle sequencer (RAM1/RAM2/ROM) with wait states, dtack and berr
// Optional: define EXTMEM_SEQ_ROM_WP_EN to turn ROM writes into bus errors instead of silently dropping them.
module extmem_seq #(
  parameter int RAM_WAIT       = 1,
  parameter int ROM_WAIT       = 3,
  parameter int STROBE_TIMEOUT = 63
) (
  input  logic sysclk,
  input  logic sysrst,
  input  logic as,
  input  logic w_n,
  input  logic lds_n,
  input  logic uds_n,
  input  logic csram1,
  input  logic csram2,
  input  logic csrom,
  output logic csram1_n,
  output logic csram2_n,
  output logic csrom_n,
  output logic re_n,
  output logic we_n,
  output logic ble_n,
  output logic bhe_n,
  output logic dtack,
  output logic berr,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    ACK     = 3'd3,
    FAULT   = 3'd4,
    RECOVER = 3'd5
  } state_t;

  typedef struct packed {
    logic csram1_n;
    logic csram2_n;
    logic csrom_n;
    logic re_n;
    logic we_n;
    logic ble_n;
    logic bhe_n;
    logic dtack;
    logic berr;
    logic busy;
  } out_t;

  localparam out_t OUT_IDLE  = out_t'(10'b1111111000);
  localparam out_t OUT_BUSY  = out_t'(10'b1111111001);
  localparam out_t OUT_FAULT = out_t'(10'b1111111011);

`ifdef EXTMEM_SEQ_ROM_WP_EN
  localparam bit ROM_WP = 1'b1;
`else
  localparam bit ROM_WP = 1'b0;
`endif

  state_t     state;
  out_t       o;
  logic       dir_wr;
  logic       tgt_rom;
  logic [3:0] wait_cnt;
  logic [7:0] to_cnt;

  logic [2:0] cs_vec;
  logic       cs_one;
  logic       cs_multi;
  logic       strobe;

  assign cs_vec   = {csrom, csram2, csram1};
  assign cs_one   = (cs_vec == 3'b001) || (cs_vec == 3'b010) || (cs_vec == 3'b100);
  assign cs_multi = (csram1 & csram2) | (csram1 & csrom) | (csram2 & csrom);
  assign strobe   = ~lds_n | ~uds_n;

  always_ff @(posedge sysclk) begin
    if (sysrst) begin
      state    <= IDLE;
      o        <= OUT_IDLE;
      dir_wr   <= 1'b0;
      tgt_rom  <= 1'b0;
      wait_cnt <= 4'd0;
      to_cnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (as && cs_one) begin
            state      <= SETUP;
            dir_wr     <= ~w_n;
            tgt_rom    <= csrom;
            wait_cnt   <= csrom ? 4'(ROM_WAIT) : 4'(RAM_WAIT);
            to_cnt     <= 8'd0;
            o          <= OUT_BUSY;
            o.csram1_n <= ~csram1;
            o.csram2_n <= ~csram2;
            o.csrom_n  <= ~csrom;
            // Read lanes follow the strobes from the start; write lanes wait for data strobes.
            if (w_n) begin
              o.ble_n <= lds_n;
              o.bhe_n <= uds_n;
            end
          end else if (as && cs_multi) begin
            state <= FAULT;
            o     <= OUT_FAULT;
          end
        end

        SETUP: begin
          if (!as) begin
            state <= RECOVER;
            o     <= OUT_BUSY;
          end else if (!dir_wr) begin
            state   <= ACCESS;
            o.re_n  <= 1'b0;
            o.ble_n <= lds_n;
            o.bhe_n <= uds_n;
          end else if (strobe && ROM_WP && tgt_rom) begin
            state <= FAULT;
            o     <= OUT_FAULT;
          end else if (strobe) begin
            state   <= ACCESS;
            o.we_n  <= tgt_rom;
            o.ble_n <= lds_n;
            o.bhe_n <= uds_n;
          end else if (to_cnt + 8'd1 == 8'(STROBE_TIMEOUT)) begin
            state <= FAULT;
            o     <= OUT_FAULT;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end

        ACCESS: begin
          if (!as) begin
            state <= RECOVER;
            o     <= OUT_BUSY;
          end else if (wait_cnt == 4'd0) begin
            // we_n rises on ACK entry so the write data is held past the strobe edge.
            state   <= ACK;
            o.we_n  <= 1'b1;
            o.dtack <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        ACK: begin
          if (!as) begin
            state <= RECOVER;
            o     <= OUT_BUSY;
          end
        end

        FAULT: begin
          if (!as) begin
            state <= RECOVER;
            o     <= OUT_BUSY;
          end
        end

        RECOVER: begin
          state <= IDLE;
          o     <= OUT_IDLE;
        end

        default: begin
          state <= IDLE;
          o     <= OUT_IDLE;
        end
      endcase
    end
  end

  assign csram1_n = o.csram1_n;
  assign csram2_n = o.csram2_n;
  assign csrom_n  = o.csrom_n;
  assign re_n     = o.re_n;
  assign we_n     = o.we_n;
  assign ble_n    = o.ble_n;
  assign bhe_n    = o.bhe_n;
  assign dtack    = o.dtack;
  assign berr     = o.berr;
  assign busy     = o.busy;

endmodule
